// File: rtl/hpdcache_ram_1rw_port_pkg.sv
// Shared definitions for the 1RW SRAM request front end.
// Everything width-dependent stays local to the modules. This package only
// names which channel owns the SRAM port in a given cycle.
package hpdcache_ram_1rw_port_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } ram_gnt_e;

endpackage

// File: rtl/hpdcache_ram_1rw_port_rsp_fifo.sv
// Small ring-buffer FIFO that holds SRAM read responses until they are consumed.
// Head and tail wrap at DEPTH, so DEPTH does not have to be a power of two.
// A push and a pop in the same cycle are allowed even when the FIFO is full.
module hpdcache_ram_1rw_port_rsp_fifo #(
    parameter  int unsigned DEPTH = 3,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [OCC_W-1:0] occ_o
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // Advance the pointers and track occupancy from the push/pop pair
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push_i) begin
            tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
        end
        if (pop_i) begin
            head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Write the incoming response into the slot under the tail pointer
    always_comb begin
        mem_d = mem_q;
        if (push_i) begin
            mem_d[tail_q] = push_data_i;
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Storage needs no reset because occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data_o = mem_q[head_q];
    assign full_o      = (occ_q == OCC_FULL);
    assign empty_o     = (occ_q == '0);
    assign occ_o       = occ_q;

endmodule

// File: rtl/hpdcache_ram_1rw_port.sv
// Request-side front end for a single-port SRAM with a one-cycle read latency.
// Write and read channels share the port. Writes win by default, but a
// streak counter bounds how long an eligible read can be held off. Read data
// lands in a response FIFO, so responses survive downstream backpressure.
module hpdcache_ram_1rw_port
    import hpdcache_ram_1rw_port_pkg::*;
#(
    parameter int unsigned ADDR_SIZE     = 8,
    parameter int unsigned DATA_SIZE     = 64,
    parameter int unsigned RSP_DEPTH     = 3,
    parameter int unsigned WR_STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [ADDR_SIZE-1:0] wr_addr_i,
    input  logic [DATA_SIZE-1:0] wr_data_i,
    input  logic [DATA_SIZE-1:0] wr_mask_i,
    input  logic                 rd_valid_i,
    output logic                 rd_ready_o,
    input  logic [ADDR_SIZE-1:0] rd_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATA_SIZE-1:0] rsp_data_o,
    output logic                 ram_cs_o,
    output logic                 ram_we_o,
    output logic [ADDR_SIZE-1:0] ram_addr_o,
    output logic [DATA_SIZE-1:0] ram_wdata_o,
    output logic [DATA_SIZE-1:0] ram_wmask_o,
    input  logic [DATA_SIZE-1:0] ram_rdata_i
);

    localparam int unsigned OCC_W    = $clog2(RSP_DEPTH + 1);
    localparam int unsigned STREAK_W = $clog2(WR_STARVE_MAX + 1);
    localparam logic [OCC_W:0]      DEPTH_LIM  = (OCC_W + 1)'(RSP_DEPTH);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(WR_STARVE_MAX);

    logic [OCC_W-1:0]    fifo_occ;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [OCC_W:0]      pending;
    logic                rd_elig;
    ram_gnt_e            gnt;
    logic                inflight_q, inflight_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    // A read is eligible only if its response has a reserved FIFO slot; pops in this cycle are ignored
    always_comb begin
        pending = {1'b0, fifo_occ} + {{OCC_W{1'b0}}, inflight_q};
        rd_elig = rd_valid_i && !fifo_full && (pending < DEPTH_LIM);
    end

    // Single-grant arbiter: write first, unless the read has been starved or no write is pending
    always_comb begin
        gnt = GNT_NONE;
        if (rst_n) begin
            if (rd_elig && ((streak_q == STREAK_MAX) || !wr_valid_i)) begin
                gnt = GNT_RD;
            end else if (wr_valid_i) begin
                gnt = GNT_WR;
            end
        end
    end

    // Count writes that overtook an eligible read and track the outstanding SRAM read
    always_comb begin
        streak_d   = streak_q;
        inflight_d = (gnt == GNT_RD);
        if ((gnt == GNT_RD) || !rd_elig) begin
            streak_d = '0;
        end else if ((gnt == GNT_WR) && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Drive the SRAM pins straight from the grant and zero every field the grant does not use
    always_comb begin
        ram_cs_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        case (gnt)
            GNT_WR: begin
                ram_cs_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = wr_addr_i;
                ram_wdata_o = wr_data_i;
                ram_wmask_o = wr_mask_i;
            end
            GNT_RD: begin
                ram_cs_o   = 1'b1;
                ram_addr_o = rd_addr_i;
            end
            default: begin
                ram_cs_o = 1'b0;
            end
        endcase
    end

    // Arbiter state; a read in flight at reset is dropped because inflight clears
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            streak_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            streak_q   <= streak_d;
        end
    end

    assign wr_ready_o  = (gnt == GNT_WR);
    assign rd_ready_o  = (gnt == GNT_RD);
    assign fifo_pop    = rsp_ready_i && !fifo_empty;
    assign rsp_valid_o = !fifo_empty;

    hpdcache_ram_1rw_port_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_SIZE)
    ) i_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (ram_rdata_i),
        .pop_i       (fifo_pop),
        .head_data_o (rsp_data_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .occ_o       (fifo_occ)
    );

endmodule

// File: tb/tb_hpdcache_ram_1rw_port.sv
// Self-checking bench for hpdcache_ram_1rw_port.
// A behavioural SRAM sits on the RAM pins. A transaction-level model predicts
// grants, pin values and the ordered stream of read responses.
module tb_hpdcache_ram_1rw_port;

    localparam int ADDR_SIZE     = 8;
    localparam int DATA_SIZE     = 64;
    localparam int RSP_DEPTH     = 3;
    localparam int WR_STARVE_MAX = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 wr_valid_i;
    logic                 wr_ready_o;
    logic [ADDR_SIZE-1:0] wr_addr_i;
    logic [DATA_SIZE-1:0] wr_data_i;
    logic [DATA_SIZE-1:0] wr_mask_i;
    logic                 rd_valid_i;
    logic                 rd_ready_o;
    logic [ADDR_SIZE-1:0] rd_addr_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [DATA_SIZE-1:0] rsp_data_o;
    logic                 ram_cs_o;
    logic                 ram_we_o;
    logic [ADDR_SIZE-1:0] ram_addr_o;
    logic [DATA_SIZE-1:0] ram_wdata_o;
    logic [DATA_SIZE-1:0] ram_wmask_o;
    logic [DATA_SIZE-1:0] ram_rdata_i;

    hpdcache_ram_1rw_port #(
        .ADDR_SIZE     (ADDR_SIZE),
        .DATA_SIZE     (DATA_SIZE),
        .RSP_DEPTH     (RSP_DEPTH),
        .WR_STARVE_MAX (WR_STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid_i  (wr_valid_i),
        .wr_ready_o  (wr_ready_o),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .wr_mask_i   (wr_mask_i),
        .rd_valid_i  (rd_valid_i),
        .rd_ready_o  (rd_ready_o),
        .rd_addr_i   (rd_addr_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .ram_cs_o    (ram_cs_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_wmask_o (ram_wmask_o),
        .ram_rdata_i (ram_rdata_i)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1RW SRAM: bit-masked write, registered read data
    logic [DATA_SIZE-1:0] ramMem [256];
    always @(posedge clk) begin
        if (ram_cs_o) begin
            if (ram_we_o) begin
                ramMem[ram_addr_o] <= (ramMem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
            end else begin
                ram_rdata_i <= ramMem[ram_addr_o];
            end
        end
    end

    typedef struct {
        logic [DATA_SIZE-1:0] data;
        int                   due;
    } rspT;

    rspT                  expQ [$];
    logic [DATA_SIZE-1:0] refMem [256];
    int                   refStreak;
    int                   cycleNum;
    int                   totalCount;
    int                   badCount;
    logic                 lastRdGnt;
    logic                 lastRspValid;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cycleNum, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check the DUT against the model mid-cycle, then advance the model
    task automatic applyStimulus(input logic rstn, input logic wv, input logic [7:0] wa,
                                 input logic [63:0] wd, input logic [63:0] wm,
                                 input logic rv, input logic [7:0] ra, input logic rr);
        logic expWr, expRd, elig, expValid;
        rst_n       = rstn;
        wr_valid_i  = wv;
        wr_addr_i   = wa;
        wr_data_i   = wd;
        wr_mask_i   = wm;
        rd_valid_i  = rv;
        rd_addr_i   = ra;
        rsp_ready_i = rr;
        @(negedge clk);

        elig  = rstn && rv && (expQ.size() < RSP_DEPTH);
        expRd = elig && ((refStreak == WR_STARVE_MAX) || !wv);
        expWr = rstn && wv && !expRd;

        checkOutput("wr_ready", {63'd0, wr_ready_o}, {63'd0, expWr});
        checkOutput("rd_ready", {63'd0, rd_ready_o}, {63'd0, expRd});
        checkOutput("ram_cs", {63'd0, ram_cs_o}, {63'd0, expWr || expRd});
        checkOutput("ram_we", {63'd0, ram_we_o}, {63'd0, expWr});
        checkOutput("ram_addr", {56'd0, ram_addr_o}, expWr ? {56'd0, wa} : (expRd ? {56'd0, ra} : 64'd0));
        checkOutput("ram_wdata", ram_wdata_o, expWr ? wd : 64'd0);
        checkOutput("ram_wmask", ram_wmask_o, expWr ? wm : 64'd0);
        lastRdGnt    = rd_ready_o;
        lastRspValid = rsp_valid_o;

        expValid = (expQ.size() > 0) && (expQ[0].due <= cycleNum);
        if (rstn) begin
            checkOutput("rsp_valid", {63'd0, rsp_valid_o}, {63'd0, expValid});
            if (expValid) begin
                checkOutput("rsp_data", rsp_data_o, expQ[0].data);
            end
        end

        if (!rstn) begin
            expQ.delete();
            refStreak = 0;
        end else begin
            if (rr && expValid) begin
                void'(expQ.pop_front());
            end
            if (expWr) begin
                refMem[wa] = (refMem[wa] & ~wm) | (wd & wm);
            end
            if (expRd) begin
                expQ.push_back('{data: refMem[ra], due: cycleNum + 2});
            end
            if (expRd || !elig) begin
                refStreak = 0;
            end else if (expWr && (refStreak < WR_STARVE_MAX)) begin
                refStreak++;
            end
        end
        cycleNum++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rdCount;
        int popCount;
        logic [5:0] pattern;

        totalCount = 0;
        badCount   = 0;
        cycleNum   = 0;
        refStreak  = 0;
        ram_rdata_i = '0;
        for (int i = 0; i < 256; i++) begin
            ramMem[i] = '0;
            refMem[i] = '0;
        end

        // Reset: everything idle while rst_n is low, then no response visible
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h01, 64'h1, 64'h1, 1, 8'h01, 1);
        checkOutput("reset_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);

        // Single write followed by a read of the same word
        applyStimulus(1, 1, 8'h05, 64'h1122334455667788, 64'hFFFF_FFFF_FFFF_FFFF, 0, 8'h00, 0);
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 1, 8'h05, 0);
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 0);
        checkOutput("t1_valid", {63'd0, rsp_valid_o}, 64'd1);
        checkOutput("t1_data", rsp_data_o, 64'h1122334455667788);
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 1);

        // Partial-mask write over an all-ones word
        applyStimulus(1, 1, 8'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 8'h00, 1);
        applyStimulus(1, 1, 8'h20, 64'h0, 64'h0000_0000_FFFF_0000, 0, 8'h00, 1);
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 1, 8'h20, 0);
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 0);
        checkOutput("t2_data", rsp_data_o, 64'hFFFF_FFFF_0000_FFFF);
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 1);

        // Same-address write and read together: write goes first, read sees new data
        applyStimulus(1, 1, 8'h10, 64'hA5, 64'hFFFF_FFFF_FFFF_FFFF, 1, 8'h10, 0);
        checkOutput("t3_first_rd", {63'd0, lastRdGnt}, 64'd0);
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 1, 8'h10, 0);
        checkOutput("t3_second_rd", {63'd0, lastRdGnt}, 64'd1);
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 0);
        checkOutput("t3_data", rsp_data_o, 64'hA5);
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 1);

        // Starvation bound: W,W,W,W,R,W with writes valid every cycle
        pattern = '0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 8'(8'h40 + i), 64'(i), 64'hFF, 1, 8'h05, 1);
            pattern[i] = lastRdGnt;
        end
        checkOutput("t4_pattern", {58'd0, pattern}, 64'b010000);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 1);

        // Backpressure: only RSP_DEPTH reads accepted, then an ordered drain
        rdCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 1, 8'(i == 0 ? 8'h05 : (i == 1 ? 8'h20 : 8'h10)), 0);
            rdCount += int'(lastRdGnt);
        end
        checkOutput("t5_accepted", 64'(rdCount), 64'd3);
        popCount = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 1);
            popCount += int'(lastRspValid);
        end
        checkOutput("t5_drained", 64'(popCount), 64'd3);

        // Reset one cycle after a read grant: the response must vanish
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 1, 8'h20, 0);
        applyStimulus(0, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 0);
            checkOutput("t6_no_stale", {63'd0, rsp_valid_o}, 64'd0);
        end
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 1, 8'h05, 0);
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 0);
        checkOutput("t6_fresh_data", rsp_data_o, 64'h1122334455667788);
        applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 1);

        // Randomized traffic over a small address window with occasional resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) != 0),
                          ($urandom_range(0, 99) < 60),
                          8'($urandom_range(0, 15)),
                          {$urandom, $urandom},
                          ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom},
                          ($urandom_range(0, 99) < 60),
                          8'($urandom_range(0, 15)),
                          ($urandom_range(0, 99) < 70));
        end
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 1);
        checkOutput("final_empty", {63'd0, rsp_valid_o}, 64'd0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
